player_move: RTL and testbench
==============================

// Module: player_move
// PURPOSE
//  Player position controller feeding random_generate (player_x/player_y).
//  Synchronizes four direction buttons and moves the player once per video frame.
//  Speed ramps up while a direction is held. Position is clamped to the 1024x768 visible area.
//  Outputs are registered centre coordinates; the draw and collision stages consume them.
// PARAMETERS
//  START_X       512  reset x centre coordinate
//  START_Y       384  reset y centre coordinate
//  SPEED_MIN     1    pixels per frame on first held frame
//  SPEED_MAX     8    saturation speed, pixels per frame
//  ACCEL_FRAMES  8    held frames per +1 speed step
// PORTS
//  clk         in   1   system/pixel clock
//  rst         in   1   reset; asynchronous, active-low
//  frame_tick  in   1   1-cycle pulse per frame (start of vblank)
//  btn_up      in   1   raw button, asynchronous
//  btn_down    in   1   raw button, asynchronous
//  btn_left    in   1   raw button, asynchronous
//  btn_right   in   1   raw button, asynchronous
//  player_x    out  10  player centre x
//  player_y    out  10  player centre y
//  moving      out  1   1 while FSM is in MOVE
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst=0 resets).
//    Reset values: player_x=START_X, player_y=START_Y, moving=0, speed=SPEED_MIN, frame_cnt=0,
//    FSM=IDLE, synchronizer flops=0.
//  - Buttons pass through a 2-FF synchronizer. Direction logic uses only the synchronized values.
//  - Effective axis direction: dx=+1 (right only), -1 (left only), 0 (both or none); dy likewise (down=+1).
//  - All state changes happen only in cycles with frame_tick=1. Outputs change on the clock edge that
//    samples frame_tick (visible the cycle after). Without frame_tick, all state holds.
//  - FSM (on frame_tick):
//     IDLE: dx|dy != 0 -> MOVE; apply a move at SPEED_MIN; frame_cnt=1 (or speed step if ACCEL_FRAMES=1).
//           Otherwise stay in IDLE.
//     MOVE: dx|dy != 0 -> move by speed. If frame_cnt==ACCEL_FRAMES-1: frame_cnt=0 and
//           speed=min(speed+1,SPEED_MAX). Else frame_cnt+1.
//           dx==dy==0 -> IDLE; speed=SPEED_MIN; frame_cnt=0; no move.
//  - Diagonal moves apply full speed on both axes (no normalisation).
//  - Arithmetic: next = pos + d*speed, computed in 12-bit signed. Clamp x to
//    [PLAYER_SIZE, HOR_PIXELS-1-PLAYER_SIZE] and y to [PLAYER_SIZE, VER_PIXELS-1-PLAYER_SIZE].
//    No wrap-around ever; the player stays in MOVE while pressed against an edge.
//  - Button change between ticks: only the value present at the tick matters.
//  - Reset mid-motion: immediate return to reset values; ramp restarts from SPEED_MIN.
// STRUCTURE
//  - vga_pkg: HOR_PIXELS(1024), VER_PIXELS(768), PLAYER_SIZE (shared with random_generate and draw).
//  - Local typedef enum logic {IDLE, MOVE} state_t; move to vga_pkg only if another block needs it.
//  - Sub-module btn_sync: 2-FF synchronizer, parameterised width (4 here). Reusable by other input paths.
//  - Remaining logic: one always_ff (async active-low reset) plus one always_comb next-state/clamp block.
// TESTING (PLAYER_SIZE=16, defaults otherwise)
//  1. rst=0 mid-run -> same cycle: player_x=512, player_y=384, moving=0. Release, no buttons, 5 ticks -> unchanged.
//  2. Hold btn_right; 3 frame_ticks -> player_x=513,514,515; moving=1; player_y=384.
//     Hold without ticks for 1000 cycles -> no change.
//  3. Hold btn_right; 20 ticks from 512 -> 8x1 + 8x2 + 4x3 = 548. Release, 1 tick -> x=548, moving=0.
//     Re-press -> next step is +1.
//  4. Start x=20, hold btn_left -> x=19..16 then stays at 16 (never wraps).
//     Hold btn_down from y=700 for 40 ticks -> y saturates at 751.
//  5. btn_left and btn_right together, 10 ticks -> x unchanged, moving=0.
//     Add btn_up -> only y decreases.
//  6. Ramp until speed reaches 8 (>=56 ticks), then 16 more ticks -> step stays 8/tick.
//     Assert rst for 1 cycle between ticks -> back to 512/384; first post-reset step is +1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared screen geometry and coordinate clamp used by the player, spawn and draw stages.
package vga_pkg;

  localparam int HOR_PIXELS  = 1024;
  localparam int VER_PIXELS  = 768;
  localparam int PLAYER_SIZE = 16;

  // Legal centre-coordinate window so the whole sprite stays on screen.
  localparam logic signed [11:0] X_LO = 12'(PLAYER_SIZE);
  localparam logic signed [11:0] X_HI = 12'(HOR_PIXELS - 1 - PLAYER_SIZE);
  localparam logic signed [11:0] Y_LO = 12'(PLAYER_SIZE);
  localparam logic signed [11:0] Y_HI = 12'(VER_PIXELS - 1 - PLAYER_SIZE);

  // Saturate a signed 12-bit candidate coordinate into [lo, hi]; never wraps.
  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic signed [11:0] lo,
                                             input logic signed [11:0] hi);
    logic signed [11:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[9:0];
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for asynchronous level inputs, any width.
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of raw inputs into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/player_move.sv
// Player position controller: one move per frame, speed ramps while held,
// centre clamped to the visible area.
//   state | meaning
//   IDLE  | no effective direction at last tick; speed parked at SPEED_MIN
//   MOVE  | a direction was active at last tick; ramping speed
module player_move
  import vga_pkg::*;
#(
  parameter int START_X      = 512,
  parameter int START_Y      = 384,
  parameter int SPEED_MIN    = 1,
  parameter int SPEED_MAX    = 8,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       moving
);

  localparam int SPD_W = $clog2(SPEED_MAX + 1);
  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [SPD_W-1:0] SPD_MIN_V = SPD_W'(SPEED_MIN);
  localparam logic [SPD_W-1:0] SPD_MAX_V = SPD_W'(SPEED_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACCEL_FRAMES - 1);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       btn_s;  // {up, down, left, right}
  logic             go_r, go_l, go_d, go_u;
  logic signed [11:0] step, x_sum, y_sum;

  btn_sync #(.WIDTH(4)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   ({btn_up, btn_down, btn_left, btn_right}),
    .q   (btn_s)
  );

  // Opposing buttons cancel on each axis.
  assign go_r = btn_s[0] & ~btn_s[1];
  assign go_l = btn_s[1] & ~btn_s[0];
  assign go_d = btn_s[2] & ~btn_s[3];
  assign go_u = btn_s[3] & ~btn_s[2];

  // Next-state, speed ramp and clamped position; everything holds between frame ticks.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    step    = $signed(12'(spd_q));
    x_sum   = $signed({2'b00, x_q});
    y_sum   = $signed({2'b00, y_q});
    if (go_r)      x_sum = x_sum + step;
    else if (go_l) x_sum = x_sum - step;
    if (go_d)      y_sum = y_sum + step;
    else if (go_u) y_sum = y_sum - step;

    if (frame_tick) begin
      if (go_r | go_l | go_d | go_u) begin
        // IDLE always holds speed at SPEED_MIN and count at 0, so one path serves both states.
        state_d = MOVE;
        x_d     = clamp_coord(x_sum, X_LO, X_HI);
        y_d     = clamp_coord(y_sum, Y_LO, Y_HI);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (spd_q < SPD_MAX_V) spd_d = spd_q + SPD_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = IDLE;
        spd_d   = SPD_MIN_V;
        cnt_d   = '0;
      end
    end
  end

  // State, position and ramp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      spd_q   <= SPD_MIN_V;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign player_x = x_q;
  assign player_y = y_q;
  assign moving   = (state_q == MOVE);

endmodule

// File: tb/tb_player_move.sv
// Scoreboard bench for player_move: a behavioural model predicts each frame's result.
module tb_player_move;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0] player_x, player_y;
  logic       moving;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int x;
    int y;
    bit mov;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // reference model state
  int m_x, m_y, m_spd, m_cnt;
  bit m_mov;

  player_move dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .player_x   (player_x),
    .player_y   (player_y),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_x = 512; m_y = 384; m_spd = 1; m_cnt = 0; m_mov = 0;
  endtask

  task automatic model_tick();
    int dx, dy;
    dx = (btn_right && !btn_left) ? 1 : (btn_left && !btn_right) ? -1 : 0;
    dy = (btn_down && !btn_up) ? 1 : (btn_up && !btn_down) ? -1 : 0;
    if (dx != 0 || dy != 0) begin
      m_x = clampi(m_x + dx * m_spd, 16, 1007);
      m_y = clampi(m_y + dy * m_spd, 16, 751);
      m_mov = 1;
      if (m_cnt == 7) begin
        m_cnt = 0;
        if (m_spd < 8) m_spd++;
      end else m_cnt++;
    end else begin
      m_mov = 0; m_spd = 1; m_cnt = 0;
    end
  endtask

  // Change buttons, then let them cross the synchronizer before any tick.
  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    repeat (3) @(negedge clk);
  endtask

  // One frame tick; expected result queued, DUT sampled at the following negedge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    model_tick();
    sb.push_back('{x: m_x, y: m_y, mov: m_mov});
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_btn(0, 1, 0, 1);
    repeat (4) begin
      tick();
      e = sb.pop_front();
    end
    // async reset mid-cycle: outputs must return without an edge
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    compared++;
    if (player_x !== 10'd512 || player_y !== 10'd384 || moving !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async: got x=%0d y=%0d mov=%0b want 512 384 0", player_x, player_y, moving);
    end
    model_reset();
    btn_down = 0; btn_right = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    repeat (5) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'(e.x) || player_y !== 10'(e.y) || moving !== e.mov || e.x != 512) begin
        mismatched++;
        $display("FAIL reset_idle: got %0d/%0d/%0b want %0d/%0d/%0b", player_x, player_y, moving, e.x, e.y, e.mov);
      end
    end
  endtask

  task automatic test_single_step();
    do_reset();
    set_btn(0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'(e.x) || player_y !== 10'd384 || moving !== 1'b1 || e.x != 512 + i) begin
        mismatched++;
        $display("FAIL single_step[%0d]: got %0d/%0d/%0b want %0d/384/1", i, player_x, player_y, moving, 512 + i);
      end
    end
    repeat (1000) @(negedge clk);
    compared++;
    if (player_x !== 10'd515 || player_y !== 10'd384 || moving !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_no_tick: got %0d/%0d/%0b want 515/384/1", player_x, player_y, moving);
    end
  endtask

  task automatic test_ramp();
    do_reset();
    set_btn(0, 0, 0, 1);
    repeat (20) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'(e.x) || player_y !== 10'(e.y) || moving !== e.mov) begin
        mismatched++;
        $display("FAIL ramp: got %0d/%0d/%0b want %0d/%0d/%0b", player_x, player_y, moving, e.x, e.y, e.mov);
      end
    end
    compared++;
    if (player_x !== 10'd548) begin
      mismatched++;
      $display("FAIL ramp_20: got x=%0d want 548", player_x);
    end
    set_btn(0, 0, 0, 0);
    tick();
    e = sb.pop_front();
    compared++;
    if (player_x !== 10'd548 || moving !== 1'b0 || e.x != 548 || e.mov) begin
      mismatched++;
      $display("FAIL release: got x=%0d mov=%0b want 548 0", player_x, moving);
    end
    set_btn(0, 0, 0, 1);
    tick();
    e = sb.pop_front();
    compared++;
    if (player_x !== 10'd549 || moving !== 1'b1 || e.x != 549) begin
      mismatched++;
      $display("FAIL repress: got x=%0d mov=%0b want 549 1", player_x, moving);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    set_btn(0, 0, 1, 0);
    repeat (100) begin
      tick();
      e = sb.pop_front();
    end
    compared++;
    if (player_x !== 10'd16 || e.x != 16) begin
      mismatched++;
      $display("FAIL clamp_left_sat: got x=%0d want 16", player_x);
    end
    set_btn(0, 0, 0, 0);
    tick();
    e = sb.pop_front();
    set_btn(0, 0, 0, 1);
    repeat (4) begin
      tick();
      e = sb.pop_front();
    end
    compared++;
    if (player_x !== 10'd20) begin
      mismatched++;
      $display("FAIL clamp_setup: got x=%0d want 20", player_x);
    end
    set_btn(0, 0, 0, 0);
    tick();
    e = sb.pop_front();
    set_btn(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'(e.x) || moving !== 1'b1 || e.x != ((19 - i) < 16 ? 16 : (19 - i))) begin
        mismatched++;
        $display("FAIL clamp_left[%0d]: got x=%0d mov=%0b want %0d 1", i, player_x, moving, e.x);
      end
    end
    set_btn(0, 1, 0, 0);
    repeat (80) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_y !== 10'(e.y) || player_x !== 10'(e.x)) begin
        mismatched++;
        $display("FAIL clamp_down: got %0d/%0d want %0d/%0d", player_x, player_y, e.x, e.y);
      end
    end
    compared++;
    if (player_y !== 10'd751 || moving !== 1'b1) begin
      mismatched++;
      $display("FAIL clamp_down_sat: got y=%0d mov=%0b want 751 1", player_y, moving);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_btn(0, 0, 1, 1);
    repeat (10) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'd512 || player_y !== 10'd384 || moving !== 1'b0 || e.mov) begin
        mismatched++;
        $display("FAIL conflict_lr: got %0d/%0d/%0b want 512/384/0", player_x, player_y, moving);
      end
    end
    set_btn(1, 0, 1, 1);
    repeat (3) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'd512 || player_y !== 10'(e.y) || moving !== 1'b1) begin
        mismatched++;
        $display("FAIL conflict_up: got %0d/%0d/%0b want 512/%0d/1", player_x, player_y, moving, e.y);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev_x;
    do_reset();
    set_btn(0, 0, 0, 1);
    repeat (56) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (player_x !== 10'(e.x) || moving !== e.mov) begin
        mismatched++;
        $display("FAIL max_ramp: got x=%0d mov=%0b want %0d %0b", player_x, moving, e.x, e.mov);
      end
    end
    prev_x = int'(player_x);
    repeat (16) begin
      tick();
      e = sb.pop_front();
      compared++;
      if (int'(player_x) - prev_x != 8 || player_x !== 10'(e.x)) begin
        mismatched++;
        $display("FAIL max_step: got x=%0d prev %0d want step 8", player_x, prev_x);
      end
      prev_x = int'(player_x);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (player_x !== 10'd512 || player_y !== 10'd384 || moving !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got %0d/%0d/%0b want 512/384/0", player_x, player_y, moving);
    end
    repeat (3) @(negedge clk);
    tick();
    e = sb.pop_front();
    compared++;
    if (player_x !== 10'd513 || moving !== 1'b1 || e.x != 513) begin
      mismatched++;
      $display("FAIL post_reset_step: got x=%0d mov=%0b want 513 1", player_x, moving);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_step();
    test_ramp();
    test_clamp();
    test_conflict();
    test_back_to_back();
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
